// File: rtl/decode_stage.sv
// Decode stage: 16-bit instruction split into execute control fields.
// One-entry skid buffer; jumps pulse redirect and squash wrong-path fetches.
module decode_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_instr,
  input  logic [15:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_pc,
  output logic [2:0]  out_op,
  output logic [2:0]  out_alu_fn,
  output logic [2:0]  out_rd,
  output logic [2:0]  out_rs_a,
  output logic [2:0]  out_rs_b,
  output logic [7:0]  out_imm,
  output logic        out_imm_hi,
  output logic        out_we,
  output logic        out_illegal,
  output logic        redirect,
  input  logic        redirect_done,
  input  logic        flush
);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_ALU  = 3'd1;
  localparam logic [2:0] OP_MOV  = 3'd2;
  localparam logic [2:0] OP_MOVI = 3'd3;
  localparam logic [2:0] OP_JMP  = 3'd4;

  typedef enum logic {RUN, SQUASH} state_t;

  typedef struct packed {
    logic [15:0] pc;
    logic [2:0]  op;
    logic [2:0]  fn;
    logic [2:0]  rd;
    logic [2:0]  rs_a;
    logic [2:0]  rs_b;
    logic [7:0]  imm;
    logic        imm_hi;
    logic        we;
    logic        illegal;
  } dec_t;

  state_t state_q, state_d;
  dec_t   dec_in, out_q, skid_q;
  logic   out_valid_q, skid_valid_q, redirect_q;
  logic   accept, keep, keep_jmp, out_free;
  logic [3:0] opc;

  assign opc = in_instr[15:12];

  always_comb begin
    dec_in         = '0;
    dec_in.pc      = in_pc;
    dec_in.fn      = {in_instr[8], in_instr[1:0]};
    dec_in.rd      = in_instr[11:9];
    dec_in.rs_a    = in_instr[7:5];
    dec_in.rs_b    = in_instr[4:2];
    dec_in.imm     = in_instr[7:0];
    dec_in.imm_hi  = in_instr[8];
    dec_in.op      = OP_NOP;
    dec_in.we      = 1'b0;
    dec_in.illegal = 1'b0;
    unique case (1'b1)
      opc == 4'h0: begin
        dec_in.op = OP_ALU;
        // fn 010/011 are holes in the ALU map
        if (dec_in.fn[2:1] == 2'b01)
          dec_in.illegal = 1'b1;
        else
          dec_in.we = 1'b1;
      end
      opc == 4'h4: begin
        dec_in.op = OP_MOV;
        dec_in.we = 1'b1;
      end
      opc == 4'h5: begin
        dec_in.op = OP_MOVI;
        dec_in.we = 1'b1;
      end
      opc == 4'h7: dec_in.op = OP_JMP;
      opc == 4'hf: dec_in.op = OP_NOP;
      default:     dec_in.illegal = 1'b1;
    endcase
  end

  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready;
  assign out_free = ~out_valid_q | out_ready;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= RUN;
    else
      state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = RUN;
    if (flush)
      state_d = RUN;
    else if (keep_jmp)
      state_d = SQUASH;
    else if (state_q == SQUASH && !redirect_done)
      state_d = SQUASH;
  end

  // FSM: outputs
  always_comb begin
    keep = accept & ~flush
         & ((state_q == RUN) | redirect_done);
    keep_jmp = keep & (dec_in.op == OP_JMP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      redirect_q   <= 1'b0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      redirect_q   <= 1'b0;
    end else begin
      redirect_q <= keep_jmp;
      if (out_free) begin
        if (skid_valid_q) begin
          out_q        <= skid_q;
          out_valid_q  <= 1'b1;
          skid_valid_q <= 1'b0;
        end else begin
          out_valid_q <= keep;
          if (keep)
            out_q <= dec_in;
        end
      end else if (keep) begin
        skid_q       <= dec_in;
        skid_valid_q <= 1'b1;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_q.pc;
  assign out_op      = out_q.op;
  assign out_alu_fn  = out_q.fn;
  assign out_rd      = out_q.rd;
  assign out_rs_a    = out_q.rs_a;
  assign out_rs_b    = out_q.rs_b;
  assign out_imm     = out_q.imm;
  assign out_imm_hi  = out_q.imm_hi;
  assign out_we      = out_q.we;
  assign out_illegal = out_q.illegal;
  assign redirect    = redirect_q;

endmodule
